// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic tile.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam int DEF_ROWS      = 4;
    localparam int DEF_COLS      = 4;
    localparam int DEF_WIDTH_A   = 16;
    localparam int DEF_WIDTH_B   = 16;
    localparam int DEF_WIDTH_MAC = 48;
    localparam int DEF_K_W       = 16;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_mac_cell.sv
// One PE: accumulates a_i*b_i when the act tag is valid, forwards operands/tag one register later.
// Latency 1 cycle for both the forwarded operands and the accumulator; no backpressure.
module systolic_mac_cell #(
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_MAC = 48,
    parameter bit SIGNED    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic [WIDTH_A-1:0]   a_i,
    input  logic [WIDTH_B-1:0]   b_i,
    input  logic                 v_i,
    output logic [WIDTH_A-1:0]   a_o,
    output logic [WIDTH_B-1:0]   b_o,
    output logic                 v_o,
    output logic [WIDTH_MAC-1:0] acc_o
);
    localparam int WP = WIDTH_A + WIDTH_B;

    logic [WP-1:0]        prod;
    logic [WIDTH_MAC-1:0] prod_ext;
    logic [WIDTH_MAC-1:0] acc_q, acc_d;
    logic [WIDTH_A-1:0]   a_q;
    logic [WIDTH_B-1:0]   b_q;
    logic                 v_q;

    // The low WP bits of a product of extended operands are exact for both signednesses.
    if (SIGNED) begin : g_signed
        assign prod     = {{WIDTH_B{a_i[WIDTH_A-1]}}, a_i} * {{WIDTH_A{b_i[WIDTH_B-1]}}, b_i};
        assign prod_ext = WIDTH_MAC'($signed(prod));
    end else begin : g_unsigned
        assign prod     = {{WIDTH_B{1'b0}}, a_i} * {{WIDTH_A{1'b0}}, b_i};
        assign prod_ext = WIDTH_MAC'(prod);
    end

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (v_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            v_q   <= 1'b0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            v_q   <= v_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign v_o   = v_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_os_tile.sv
// ROWS x COLS output-stationary tile: skewed operand entry, K-beat load, flush, row-by-row drain.
// Beat at cycle t reaches PE(i,j) at t+i+j; in_ready only in LOAD, drain rows stall on out_ready.
module systolic_os_tile
    import systolic_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_MAC = 48,
    parameter bit SIGNED    = 1'b0,
    parameter int K_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [K_W-1:0]                k_len,
    output logic                          busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ROWS*WIDTH_A-1:0]       act,
    input  logic [COLS*WIDTH_B-1:0]       wei,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COLS*WIDTH_MAC-1:0]     out_row,
    output logic [clog2_min1(ROWS)-1:0]   out_row_idx,
    output logic                          out_last,
    output logic                          done
);
    localparam int RI_W = clog2_min1(ROWS);
    localparam int FL_W = clog2_min1(ROWS + COLS);

    state_e          state_q, state_d;
    logic [K_W-1:0]  k_q, k_d, cnt_q, cnt_d;
    logic [FL_W-1:0] fl_q, fl_d;
    logic [RI_W-1:0] row_q, row_d;
    logic            done_q, done_d;
    logic            clr;
    logic            beat;

    logic [WIDTH_A-1:0]   a_h   [ROWS][COLS+1];
    logic                 v_h   [ROWS][COLS+1];
    logic [WIDTH_B-1:0]   b_v   [ROWS+1][COLS];
    logic [WIDTH_MAC-1:0] acc_w [ROWS][COLS];

    assign in_ready = (state_q == ST_LOAD);
    assign beat     = in_valid & in_ready;

    // Act lane i enters through i skew registers; only accepted beats carry a set tag.
    for (genvar i = 0; i < ROWS; i++) begin : g_askew
        logic [WIDTH_A-1:0] a_in;
        assign a_in = beat ? act[i*WIDTH_A +: WIDTH_A] : '0;
        if (i == 0) begin : g_d0
            assign a_h[i][0] = a_in;
            assign v_h[i][0] = beat;
        end else begin : g_dn
            logic [WIDTH_A-1:0] sa_q [i];
            logic               sv_q [i];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) begin
                        sa_q[k] <= '0;
                        sv_q[k] <= 1'b0;
                    end
                end else begin
                    sa_q[0] <= a_in;
                    sv_q[0] <= beat;
                    for (int k = 1; k < i; k++) begin
                        sa_q[k] <= sa_q[k-1];
                        sv_q[k] <= sv_q[k-1];
                    end
                end
            end
            assign a_h[i][0] = sa_q[i-1];
            assign v_h[i][0] = sv_q[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_bskew
        logic [WIDTH_B-1:0] b_in;
        assign b_in = beat ? wei[j*WIDTH_B +: WIDTH_B] : '0;
        if (j == 0) begin : g_d0
            assign b_v[0][j] = b_in;
        end else begin : g_dn
            logic [WIDTH_B-1:0] sb_q [j];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < j; k++) sb_q[k] <= '0;
                end else begin
                    sb_q[0] <= b_in;
                    for (int k = 1; k < j; k++) sb_q[k] <= sb_q[k-1];
                end
            end
            assign b_v[0][j] = sb_q[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            systolic_mac_cell #(
                .WIDTH_A  (WIDTH_A),
                .WIDTH_B  (WIDTH_B),
                .WIDTH_MAC(WIDTH_MAC),
                .SIGNED   (SIGNED)
            ) u_cell (
                .clk  (clk),
                .rst  (rst),
                .clr_i(clr),
                .a_i  (a_h[i][j]),
                .b_i  (b_v[i][j]),
                .v_i  (v_h[i][j]),
                .a_o  (a_h[i][j+1]),
                .b_o  (b_v[i+1][j]),
                .v_o  (v_h[i][j+1]),
                .acc_o(acc_w[i][j])
            );
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        fl_d    = fl_q;
        row_d   = row_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_d     = k_len;
                    cnt_d   = '0;
                    row_d   = '0;
                    clr     = 1'b1;
                    state_d = (k_len == '0) ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    cnt_d = cnt_q + K_W'(1);
                    if (cnt_d == k_q) begin
                        state_d = ST_FLUSH;
                        fl_d    = FL_W'(ROWS + COLS - 2);
                    end
                end
            end
            ST_FLUSH: begin
                if (fl_q == '0) state_d = ST_DRAIN;
                else            fl_d    = fl_q - FL_W'(1);
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (row_q == RI_W'(ROWS - 1)) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        row_d = row_q + RI_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            fl_q    <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            fl_q    <= fl_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = (state_q == ST_DRAIN);
    assign out_row_idx = row_q;
    assign out_last    = out_valid && (row_q == RI_W'(ROWS - 1));
    assign done        = done_q;

    always_comb begin
        out_row = '0;
        if (out_valid) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_q == RI_W'(r)) begin
                    for (int c = 0; c < COLS; c++) begin
                        out_row[c*WIDTH_MAC +: WIDTH_MAC] = acc_w[r][c];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_os_tile.sv
// Directed bench: 2x2 unsigned, 2x2 signed and 1x1 32-bit-accumulator tiles share one stimulus bus.
// Only the tile selected by sel sees start; the others stay idle and ignore operands.
module tb_systolic_os_tile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] k_len = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] act = '0;
    logic [31:0] wei = '0;
    int          sel = 0;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_cnt = 0;

    logic [31:0] act_tab [2];
    logic [31:0] wei_tab [2];

    logic st_u, st_s, st_w;
    assign st_u = start && (sel == 0);
    assign st_s = start && (sel == 1);
    assign st_w = start && (sel == 2);

    logic        busy_u, rdy_u, ov_u, last_u, done_u;
    logic        busy_s, rdy_s, ov_s, last_s, done_s;
    logic        busy_w, rdy_w, ov_w, last_w, done_w;
    logic [95:0] row_u, row_s;
    logic [31:0] row_w;
    logic [0:0]  idx_u, idx_s, idx_w;

    logic        busy_m, in_ready_m, out_valid_m, out_last_m, done_m;
    logic [95:0] out_row_m;
    logic [0:0]  out_row_idx_m;

    localparam logic [95:0] E_R0 = {48'd22, 48'd19};
    localparam logic [95:0] E_R1 = {48'd50, 48'd43};
    localparam logic [95:0] S_R0 = {48'd15, 48'hFFFF_FFFF_FFF4};
    localparam logic [95:0] S_R1 = {48'hFFFF_FFFF_FFF6, 48'd8};
    localparam logic [95:0] W_R0 = 96'h0000_0000_FFFC_0002;

    systolic_os_tile #(.ROWS(2), .COLS(2), .WIDTH_A(16), .WIDTH_B(16), .WIDTH_MAC(48),
                       .SIGNED(1'b0), .K_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(st_u), .k_len(k_len), .busy(busy_u),
        .in_valid(in_valid), .in_ready(rdy_u), .act(act), .wei(wei),
        .out_valid(ov_u), .out_ready(out_ready), .out_row(row_u),
        .out_row_idx(idx_u), .out_last(last_u), .done(done_u));

    systolic_os_tile #(.ROWS(2), .COLS(2), .WIDTH_A(16), .WIDTH_B(16), .WIDTH_MAC(48),
                       .SIGNED(1'b1), .K_W(16)) u_sgn (
        .clk(clk), .rst(rst), .start(st_s), .k_len(k_len), .busy(busy_s),
        .in_valid(in_valid), .in_ready(rdy_s), .act(act), .wei(wei),
        .out_valid(ov_s), .out_ready(out_ready), .out_row(row_s),
        .out_row_idx(idx_s), .out_last(last_s), .done(done_s));

    systolic_os_tile #(.ROWS(1), .COLS(1), .WIDTH_A(16), .WIDTH_B(16), .WIDTH_MAC(32),
                       .SIGNED(1'b0), .K_W(16)) u_wrap (
        .clk(clk), .rst(rst), .start(st_w), .k_len(k_len), .busy(busy_w),
        .in_valid(in_valid), .in_ready(rdy_w), .act(act[15:0]), .wei(wei[15:0]),
        .out_valid(ov_w), .out_ready(out_ready), .out_row(row_w),
        .out_row_idx(idx_w), .out_last(last_w), .done(done_w));

    always_comb begin
        busy_m        = busy_w;
        in_ready_m    = rdy_w;
        out_valid_m   = ov_w;
        out_last_m    = last_w;
        done_m        = done_w;
        out_row_m     = {64'b0, row_w};
        out_row_idx_m = idx_w;
        if (sel == 0) begin
            busy_m = busy_u; in_ready_m = rdy_u; out_valid_m = ov_u; out_last_m = last_u;
            done_m = done_u; out_row_m = row_u; out_row_idx_m = idx_u;
        end else if (sel == 1) begin
            busy_m = busy_s; in_ready_m = rdy_s; out_valid_m = ov_s; out_last_m = last_s;
            done_m = done_s; out_row_m = row_s; out_row_idx_m = idx_s;
        end
    end

    always #5 clk = ~clk;

    always @(negedge clk) if (in_ready_m) rdy_cnt = rdy_cnt + 1;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_job(input logic [15:0] k);
        @(negedge clk);
        start = 1'b1;
        k_len = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        k_len = 16'hFFFF;
        check_eq("busy_rise", busy_m, 1);
    endtask

    // Bubble cycles drive junk operands, which must never reach an accumulator.
    task automatic feed(input int k, input logic [7:0] vpat, input bit poke);
        int sent = 0;
        int c = 0;
        while (sent < k && c < 40) begin
            @(negedge clk);
            if (poke && c == 0) begin
                start = 1'b1;
                k_len = 16'd0;
            end else begin
                start = 1'b0;
            end
            in_valid = vpat[c % 8];
            if (in_valid) begin
                act = act_tab[sent];
                wei = wei_tab[sent];
            end else begin
                act = 32'hDEAD_BEEF;
                wei = 32'hBAD0_BAD0;
            end
            if (in_valid && in_ready_m) sent++;
            c++;
        end
        check_eq("beats_taken", sent, k);
    endtask

    task automatic drain(input int nrows, input logic [95:0] r0, input logic [95:0] r1,
                         input int stall0, input int lat);
        int got = 0;
        int stalls = 0;
        int cyc = 0;
        int first = 0;
        out_ready = 1'b1;
        while (got < nrows && cyc < 60) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
            start    = 1'b0;
            if (out_valid_m) begin
                if (first == 0) begin
                    first = cyc;
                    check_eq("first_valid_latency", first, lat);
                end
                check_eq("row_data", out_row_m, (got == 0) ? r0 : r1);
                check_eq("row_idx", out_row_idx_m, got);
                check_eq("row_last", out_last_m, got == nrows - 1);
                check_eq("busy_drain", busy_m, 1);
                if (got == 0 && stalls < stall0) begin
                    out_ready = 1'b0;
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                    got++;
                end
            end
        end
        check_eq("rows_drained", got, nrows);
        @(negedge clk);
        check_eq("done_pulse", done_m, 1);
        check_eq("busy_after", busy_m, 0);
        @(negedge clk);
        check_eq("done_single", done_m, 0);
    endtask

    initial begin
        int base;
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", busy_m, 0);
        check_eq("rst_in_ready", in_ready_m, 0);
        check_eq("rst_out_valid", out_valid_m, 0);
        check_eq("rst_out_row", out_row_m, 0);
        check_eq("rst_row_idx", out_row_idx_m, 0);
        check_eq("rst_last", out_last_m, 0);
        check_eq("rst_done", done_m, 0);
        @(negedge clk);
        rst = 1'b0;

        // A = [[1,2],[3,4]], B = [[5,6],[7,8]]
        act_tab[0] = {16'd3, 16'd1};
        act_tab[1] = {16'd4, 16'd2};
        wei_tab[0] = {16'd6, 16'd5};
        wei_tab[1] = {16'd8, 16'd7};

        sel = 0;
        start_job(16'd2);
        feed(2, 8'hFF, 1'b0);
        drain(2, E_R0, E_R1, 0, 4);

        start_job(16'd2);
        feed(2, 8'b0000_1001, 1'b0);
        drain(2, E_R0, E_R1, 3, 4);

        base = rdy_cnt;
        start_job(16'd0);
        drain(2, 96'd0, 96'd0, 0, 1);
        check_eq("k0_no_ready", rdy_cnt - base, 0);

        // Abort a job mid-LOAD with large operands in flight.
        start_job(16'd2);
        @(negedge clk);
        in_valid = 1'b1;
        act = 32'h0064_0064;
        wei = 32'h0064_0064;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", busy_m, 0);
        check_eq("arst_in_ready", in_ready_m, 0);
        check_eq("arst_out_valid", out_valid_m, 0);
        check_eq("arst_out_row", out_row_m, 0);
        check_eq("arst_row_idx", out_row_idx_m, 0);
        check_eq("arst_last", out_last_m, 0);
        check_eq("arst_done", done_m, 0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        start_job(16'd2);
        feed(2, 8'hFF, 1'b1);
        drain(2, E_R0, E_R1, 0, 4);

        // Signed: act = [-3, 2], wei = [4, -5]
        sel = 1;
        act_tab[0] = {16'd2, 16'hFFFD};
        wei_tab[0] = {16'hFFFB, 16'd4};
        start_job(16'd1);
        feed(1, 8'hFF, 1'b0);
        drain(2, S_R0, S_R1, 0, 4);

        // 1x1 with a 32-bit accumulator wraps.
        sel = 2;
        act_tab[0] = 32'h0000_FFFF;
        act_tab[1] = 32'h0000_FFFF;
        wei_tab[0] = 32'h0000_FFFF;
        wei_tab[1] = 32'h0000_FFFF;
        start_job(16'd2);
        feed(2, 8'hFF, 1'b0);
        drain(1, W_R0, 96'd0, 0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/systolic_os_tile.md
Name: systolic_os_tile

Overview:
- Parametrised output-stationary systolic tile, ROWS x COLS. Successor to the fixed 3x3 array.
- Adds internal input skewing, valid-tagged operand flow (bubble tolerant) and a K-beat load counter.
- Control FSM sequences clear, load, flush and a row-by-row valid/ready drain of results.
- Sits between the operand streamers (activation/weight buffers) and the result writeback path.

Parameters:
ROWS, 4, number of PE rows (activation lanes), >=1
COLS, 4, number of PE columns (weight lanes), >=1
WIDTH_A, 16, activation width
WIDTH_B, 16, weight width
WIDTH_MAC, 48, accumulator width; must be >= WIDTH_A+WIDTH_B
SIGNED, 0, 1 = two's-complement operands and product; 0 = unsigned
K_W, 16, width of the reduction-length field

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  pulse; begins a job when state is IDLE
k_len  input  K_W  reduction length K, sampled on an accepted start
busy  output  1  high whenever state is not IDLE
in_valid  input  1  operand beat valid
in_ready  output  1  tile accepts a beat (high only in LOAD)
act  input  ROWS*WIDTH_A  lane i = A[i][k], lane 0 in LSBs
wei  input  COLS*WIDTH_B  lane j = B[k][j], lane 0 in LSBs
out_valid  output  1  result row valid
out_ready  input  1  downstream accepts the row
out_row  output  COLS*WIDTH_MAC  C[r][0..COLS-1], col 0 in LSBs
out_row_idx  output  clog2(ROWS) (min 1)  row index r
out_last  output  1  high with the row r = ROWS-1
done  output  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset (async, any state): FSM to IDLE; all accumulators, skew registers and valid tags cleared. Outputs: busy=0, in_ready=0, out_valid=0, out_row=0, out_row_idx=0, out_last=0, done=0.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
  - IDLE: on start, latch k_len and clear all accumulators.
    - k_len=0: go to DRAIN; results are all zero.
    - k_len>0: go to LOAD.
  - LOAD: in_ready=1. Each handshake (in_valid & in_ready) is one beat and increments the beat counter. After the K-th beat, go to FLUSH.
    - in_valid=0 cycles inject bubbles (valid tag 0). A bubble must not alter any accumulator.
  - FLUSH: hold for exactly ROWS+COLS-1 cycles (down-counter), then go to DRAIN.
  - DRAIN: present row r=0..ROWS-1 in order. out_row, out_row_idx and out_last are held stable while out_valid & !out_ready. Advance r on each handshake. After the last row is accepted, pulse done and go to IDLE.
- start outside IDLE is ignored; k_len changes outside IDLE are ignored.
- Skew: act lane i is delayed i registers before PE(i,0); wei lane j is delayed j registers before PE(0,j). Operand, value and valid tag move one PE right (act) or down (wei) per cycle. A beat accepted at cycle t therefore reaches PE(i,j) at t+i+j. Depth-0 lanes are registered at the PE input only.
- PE(i,j): when the arriving act tag is valid, acc <= acc + act*wei, registered.
  - SIGNED=1: sign-extend the product to WIDTH_MAC.
  - SIGNED=0: zero-extend.
  - Accumulation wraps modulo 2^WIDTH_MAC; no saturation.
- Latency: the last beat at cycle T is accumulated in PE(ROWS-1,COLS-1) by the edge ending cycle T+ROWS+COLS-2. The FLUSH length covers this with one cycle of margin. The first out_valid rises in the cycle after FLUSH ends.
- In-flight bubbles behind the last beat are harmless. No new data enters outside LOAD (skew inputs are forced to tag 0).

Decomposition:
- Package systolic_pkg holds:
  - the FSM state enum (IDLE/LOAD/FLUSH/DRAIN);
  - the helper function clog2_min1;
  - the typedef-free width constants used by the benches.
- One sub-module: systolic_mac_cell. It takes act/wei/valid in, registers act/wei/valid out, and holds the accumulator with a synchronous clear and the SIGNED parameter. The tile instantiates ROWS*COLS of these plus the skew lines and FSM.

Test Plan:
- ROWS=COLS=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], out_ready=1, no bubbles -> rows [19,22] then [43,50]; out_last on row 1; done pulses once.
- Same job with in_valid toggled 1,0,0,1 and out_ready low for 3 cycles during row 0 -> identical results; row 0 held stable while stalled; bubbles add nothing.
- SIGNED=1, K=1, act=[-3,2], wei=[4,-5] -> C=[[-12,15],[8,-10]] sign-extended to 48 bits.
- k_len=0 -> busy rises, in_ready never asserts, two rows of zeros, then done.
- WIDTH_MAC=32, K=2, act=wei=0xFFFF unsigned at 1x1 -> 0x1FFFC0002 mod 2^32 = 0xFFFC0002 (wrap).
- rst asserted mid-LOAD, then a new 2x2 job -> all outputs at reset values immediately; second job's results are unaffected by the aborted job; a start pulsed during the job is ignored.
